// File: rtl/fibo_sched.sv
// rtl/fibo_sched.sv - two-client round-robin scheduler for an iterative Fibonacci engine
module fibo_sched #(
  parameter int WIDTH = 32,
  parameter int NW    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [NW-1:0]    req0_n,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [NW-1:0]    req1_n,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_value,
  output logic             rsp_ovf,
  input  logic             rsp_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ova;
  logic             ovb;
  logic [NW-1:0]    cnt;
  logic             owner;
  logic             last;

  logic             grant_id;
  logic             accept;
  logic [NW-1:0]    n_sel;
  logic [WIDTH:0]   sum;

  // Round-robin grant: a tie goes to the client that was not granted last time
  always_comb begin
    grant_id   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant_id = ~last;
      end else if (req1_valid) begin
        grant_id = 1'b1;
      end else begin
        grant_id = 1'b0;
      end
      req0_ready = req0_valid && !grant_id;
      req1_ready = req1_valid && grant_id;
    end
  end

  assign accept = req0_ready || req1_ready;
  assign n_sel  = grant_id ? req1_n : req0_n;
  // Extra top bit captures the carry-out that feeds the sticky overflow flag
  assign sum    = {1'b0, a} + {1'b0, b};
  assign busy   = (state != IDLE);

  // Sequencer: accept a request, step the a/b pair cnt times, then hold the response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      a         <= '0;
      b         <= '0;
      ova       <= 1'b0;
      ovb       <= 1'b0;
      cnt       <= '0;
      owner     <= 1'b0;
      last      <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_value <= '0;
      rsp_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a     <= '0;
            b     <= {{(WIDTH-1){1'b0}}, 1'b1};
            ova   <= 1'b0;
            ovb   <= 1'b0;
            cnt   <= n_sel;
            owner <= grant_id;
            last  <= grant_id;
            state <= CALC;
          end
        end
        CALC: begin
          if (cnt != '0) begin
            a   <= b;
            b   <= sum[WIDTH-1:0];
            // a inherits b's history, so the flag reported tracks a, not the look-ahead b
            ova <= ovb;
            ovb <= ovb | sum[WIDTH];
            cnt <= cnt - NW'(1);
          end else begin
            rsp_value <= a;
            rsp_ovf   <= ova;
            rsp_id    <= owner;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fibo_sched.sv
// tb/tb_fibo_sched.sv - directed scoreboard bench for fibo_sched
module tb_fibo_sched;

  localparam int WIDTH = 32;
  localparam int NW    = 6;

  logic             clk;
  logic             rst;
  logic             req0_valid;
  logic [NW-1:0]    req0_n;
  logic             req0_ready;
  logic             req1_valid;
  logic [NW-1:0]    req1_n;
  logic             req1_ready;
  logic             rsp_valid;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_value;
  logic             rsp_ovf;
  logic             rsp_ready;
  logic             busy;

  typedef struct {
    logic             id;
    logic [WIDTH-1:0] val;
    logic             ovf;
    int               n;
    int               c0;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   w;
  int   c_acc;

  fibo_sched #(.WIDTH(WIDTH), .NW(NW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_n     (req0_n),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_n     (req1_n),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_value  (rsp_value),
    .rsp_ovf    (rsp_ovf),
    .rsp_ready  (rsp_ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint unsigned fib(input int n);
    longint unsigned x = 0;
    longint unsigned y = 1;
    longint unsigned t;
    for (int i = 0; i < n; i++) begin
      t = x + y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic id, input int n, output int c0);
    bit   seen = 0;
    exp_t e;
    longint unsigned f;
    c0 = -1;
    if (!id) begin
      req0_valid = 1'b1;
      req0_n     = NW'(n);
    end else begin
      req1_valid = 1'b1;
      req1_n     = NW'(n);
    end
    #1;
    for (int k = 0; k < 200; k++) begin
      if ((id ? req1_ready : req0_ready) === 1'b1) begin
        seen = 1;
        break;
      end
      @(negedge clk); #1;
    end
    chk("grant_seen", {63'd0, seen}, 64'd1);
    if (seen) begin
      chk("grant_onehot", {63'd0, (id ? req0_ready : req1_ready)}, 64'd0);
      f     = fib(n);
      e.id  = id;
      e.val = f[WIDTH-1:0];
      e.ovf = (f >> WIDTH) != 0;
      e.n   = n;
      e.c0  = cyc + 1;
      c0    = e.c0;
      sb.push_back(e);
    end
    @(negedge clk); #1;
    chk("ready_pulse", {63'd0, (id ? req1_ready : req0_ready)}, 64'd0);
    chk("busy_after_accept", {63'd0, busy}, 64'd1);
    if (!id) req0_valid = 1'b0;
    else     req1_valid = 1'b0;
  endtask

  task automatic collect(input int hold, output int when);
    bit   seen = 0;
    exp_t e;
    when = -1;
    for (int k = 0; k < 300; k++) begin
      if (rsp_valid === 1'b1) begin
        seen = 1;
        break;
      end
      chk("busy_while_calc", {63'd0, busy}, 64'd1);
      @(negedge clk); #1;
    end
    chk("rsp_seen", {63'd0, seen}, 64'd1);
    chk("sb_nonempty", {63'd0, (sb.size() > 0)}, 64'd1);
    if (seen && sb.size() > 0) begin
      when = cyc;
      e = sb.pop_front();
      chk("rsp_id", {63'd0, rsp_id}, {63'd0, e.id});
      chk("rsp_value", {32'd0, rsp_value}, {32'd0, e.val});
      chk("rsp_ovf", {63'd0, rsp_ovf}, {63'd0, e.ovf});
      chk("latency", 64'(cyc - e.c0), 64'(e.n + 1));
      for (int h = 0; h < hold; h++) begin
        @(negedge clk); #1;
        chk("hold_valid", {63'd0, rsp_valid}, 64'd1);
        chk("hold_id", {63'd0, rsp_id}, {63'd0, e.id});
        chk("hold_value", {32'd0, rsp_value}, {32'd0, e.val});
        chk("hold_ovf", {63'd0, rsp_ovf}, {63'd0, e.ovf});
        chk("hold_no_grant", {62'd0, req0_ready, req1_ready}, 64'd0);
      end
    end
    if (hold > 0) rsp_ready = 1'b1;
    @(negedge clk); #1;
    chk("rsp_drop", {63'd0, rsp_valid}, 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  initial begin
    rst        = 1'b0;
    req0_valid = 1'b0;
    req0_n     = '0;
    req1_valid = 1'b0;
    req1_n     = '0;
    rsp_ready  = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_rsp_id", {63'd0, rsp_id}, 64'd0);
    chk("rst_rsp_value", {32'd0, rsp_value}, 64'd0);
    chk("rst_rsp_ovf", {63'd0, rsp_ovf}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_ready", {62'd0, req0_ready, req1_ready}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;

    // single request from client 0
    issue(1'b0, 10, c_acc);
    collect(0, w);

    // edge indices from client 1
    issue(1'b1, 0, c_acc);
    collect(0, w);
    issue(1'b1, 1, c_acc);
    collect(0, w);
    issue(1'b1, 47, c_acc);
    collect(0, w);

    // overflow cases
    issue(1'b0, 48, c_acc);
    collect(0, w);
    issue(1'b0, 63, c_acc);
    collect(0, w);

    // round robin from reset: tie goes to client 0, then client 1 in first IDLE cycle
    do_reset();
    req1_valid = 1'b1;
    req1_n     = NW'(6);
    issue(1'b0, 5, c_acc);
    collect(0, w);
    issue(1'b1, 6, c_acc);
    chk("rr_first_idle", 64'(c_acc), 64'(w + 2));
    collect(0, w);
    req1_valid = 1'b1;
    req1_n     = NW'(6);
    issue(1'b0, 5, c_acc);
    collect(0, w);
    issue(1'b1, 6, c_acc);
    chk("rr2_first_idle", 64'(c_acc), 64'(w + 2));
    collect(0, w);

    // backpressure with a pending request from client 1
    do_reset();
    rsp_ready  = 1'b0;
    req1_valid = 1'b1;
    req1_n     = NW'(3);
    issue(1'b0, 7, c_acc);
    collect(5, w);
    issue(1'b1, 3, c_acc);
    chk("bp_accept_after_hs", 64'(c_acc), 64'(w + 5 + 2));
    collect(0, w);

    // reset during CALC aborts the request
    issue(1'b0, 20, c_acc);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_rsp_value", {32'd0, rsp_value}, 64'd0);
    chk("abort_rsp_id", {63'd0, rsp_id}, 64'd0);
    if (sb.size() > 0) void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk); #1;
      chk("no_rsp_after_abort", {63'd0, rsp_valid}, 64'd0);
    end
    issue(1'b0, 20, c_acc);
    collect(0, w);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fibo_sched.md
# fibo_sched

Two-requester scheduler for a shared iterative Fibonacci engine. It sits in front of the 32-bit Fibonacci datapath and sequences it on demand. It also arbitrates between two clients with round-robin fairness: it accepts an index n from the granted client, runs the add/shift datapath for n steps, and returns F(n) with the client ID and an overflow flag over a valid/ready response channel.

## Interface
- WIDTH, 32, datapath and result width
- NW, 6, index width (n range 0..2^NW-1)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- req0_valid  in  1  client 0 request valid
- req0_n  in  NW  client 0 requested index
- req0_ready  out  1  client 0 request accepted this cycle when high with req0_valid
- req1_valid  in  1  client 1 request valid
- req1_n  in  NW  client 1 requested index
- req1_ready  out  1  client 1 request accepted this cycle when high with req1_valid
- rsp_valid  out  1  response valid
- rsp_id  out  1  client that owns the response
- rsp_value  out  WIDTH  F(n) mod 2^WIDTH
- rsp_ovf  out  1  F(n) did not fit in WIDTH bits
- rsp_ready  in  1  response consumer ready
- busy  out  1  high in any state other than IDLE

## Operation
- F(0)=0, F(1)=1, F(k)=F(k-1)+F(k-2).
- FSM states: IDLE, CALC, RESP.
- Internal registers:
  - a, b (WIDTH bits each)
  - ova, ovb (sticky overflow flags)
  - cnt (NW bits)
  - owner (1 bit)
  - last (1 bit, last granted client)
- IDLE arbitration (combinational):
  - Exactly one of req0_ready/req1_ready may be high, and only in IDLE.
  - Only one requester valid: that requester is granted.
  - Both valid: grant goes to the requester that is not `last`.
  - Nothing valid: both ready signals are low.
- Accept (valid && ready in IDLE):
  - Load a=0, b=1, ova=0, ovb=0, cnt=n.
  - owner=granted ID, last=granted ID.
  - Go to CALC.
- CALC, cnt≠0:
  - a<=b, b<=a+b (low WIDTH bits).
  - ova<=ovb.
  - ovb<=ovb | carry-out of a+b.
  - cnt<=cnt-1.
- CALC, cnt==0:
  - rsp_value<=a, rsp_ovf<=ova, rsp_id<=owner, rsp_valid<=1.
  - Go to RESP.
- RESP:
  - rsp_valid, rsp_id, rsp_value and rsp_ovf are held stable until rsp_ready is high.
  - On handshake: rsp_valid<=0, go to IDLE.
- Overflow follows a, not b. The final look-ahead b overflowing does not flag the result.
- Req inputs are sampled only at the accept edge. Later changes to req_n do not affect the calculation in flight.
- Requests are never dropped. A non-granted valid request waits in IDLE until granted.

## Timing
- Reset values:
  - rsp_valid=0, rsp_id=0, rsp_value=0, rsp_ovf=0, busy=0.
  - req0_ready/req1_ready follow IDLE arbitration.
  - State=IDLE, last=1, so client 0 wins the first tie.
  - a=0, b=0, cnt=0, ova=0, ovb=0.
- Reset asserted mid-CALC or mid-RESP: all state clears immediately. No response is issued for the aborted request.
- Latency: with the accept edge as E0, rsp_valid rises after edge E(n+1). n=0 gives 1 cycle; n=10 gives 11 cycles.
- busy rises the cycle after accept and falls the cycle after the response handshake.
- Throughput:
  - RESP→IDLE takes one edge.
  - A new request can be accepted in the first IDLE cycle.
  - Minimum spacing between accepts is n+3 cycles.
- rsp_ready high while rsp_valid is low has no effect.
- rsp_ready is ignored outside RESP.
- Maximum n = 2^NW-1 (63). The result wraps mod 2^WIDTH and rsp_ovf=1.

## Test plan
- Single request, 0 wait: client 0 sends n=10, rsp_ready=1 → req0_ready pulses for 1 cycle; rsp_valid rises 11 cycles after accept with rsp_value=55, rsp_id=0, rsp_ovf=0; busy high throughout.
- Edge indices: client 1 sends n=0, then n=1, then n=47 → responses 0, 1 and 2971215073, all with rsp_ovf=0 and rsp_id=1.
- Overflow: n=48 → rsp_value=512559680, rsp_ovf=1. n=63 → rsp_ovf=1.
- Round-robin: both clients valid from reset, client 0 with n=5 and client 1 with n=6 → grant order is 0 then 1 (values 5 then 8). Re-issuing both simultaneously gives order 0 then 1 again, since last=1 after the second grant.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid rises → all rsp_* outputs stay stable, both req_ready signals stay 0 while requests are pending, and the second request is accepted only after the handshake.
- Reset mid-operation: drop rst for 1 cycle during CALC of n=20 → outputs return to reset values immediately, no rsp_valid appears afterwards, and a fresh request for n=20 returns 6765.
